// File: rtl/nvdla_cdp_dp_lut_rd.sv
`default_nettype none
// ============================================================================
// Module   : nvdla_cdp_dp_lut_rd
// Desc     : CDP LUT read stage. Reads the (N, N+1) entry pair from the LE and
//            LO tables per lane, then picks the winning table for interpolation.
//            Optional readback port: define NVDLA_CDP_LUT_RDBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nvdla_cdp_dp_lut_rd #(
    parameter int LANES    = 1,
    parameter int LE_DEPTH = 65,
    parameter int LO_DEPTH = 257
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  dp2lut_pvld,
    output logic                  dp2lut_prdy,
    input  logic [LANES*10-1:0]   dp2lut_X_entry,
    input  logic [LANES*18-1:0]   dp2lut_Xinfo,
    input  logic [LANES*10-1:0]   dp2lut_Y_entry,
    input  logic [LANES*18-1:0]   dp2lut_Yinfo,
    input  logic                  reg2dp_lut_hybrid_priority,
    input  logic                  reg2dp_lut_uflow_priority,
    input  logic                  reg2dp_lut_oflow_priority,
    input  logic                  lut_wr_en,
    input  logic                  lut_wr_table,
    input  logic [8:0]            lut_wr_addr,
    input  logic [15:0]           lut_wr_data,
`ifdef NVDLA_CDP_LUT_RDBACK_EN
    input  logic                  lut_rd_en,
    input  logic                  lut_rd_table,
    input  logic [8:0]            lut_rd_addr,
    output logic [15:0]           lut_rd_data,
`endif
    output logic                  lut2intp_pvld,
    input  logic                  lut2intp_prdy,
    output logic [LANES*16-1:0]   lut2intp_data0,
    output logic [LANES*16-1:0]   lut2intp_data1,
    output logic [LANES*16-1:0]   lut2intp_frac,
    output logic [LANES-1:0]      lut2intp_sel,
    output logic [LANES*4-1:0]    lut2intp_flag
);

    localparam int         LE_AW      = $clog2(LE_DEPTH);
    localparam int         LO_AW      = $clog2(LO_DEPTH);
    localparam logic [9:0] LE_LAST    = 10'(LE_DEPTH - 1);
    localparam logic [9:0] LO_LAST    = 10'(LO_DEPTH - 1);
    localparam logic [8:0] LE_DEPTH_A = 9'(LE_DEPTH);
    localparam logic [8:0] LO_DEPTH_A = 9'(LO_DEPTH);

    logic [15:0] le_tab_q [LE_DEPTH];
    logic [15:0] lo_tab_q [LO_DEPTH];
    logic        le_we, lo_we;

    logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s1_adv, s2_adv;

    logic [LANES-1:0][9:0]  x_ent, y_ent, x_n, x_n1, y_n, y_n1;
    logic [LANES-1:0][15:0] le_d0_q, le_d0_d, le_d1_q, le_d1_d;
    logic [LANES-1:0][15:0] lo_d0_q, lo_d0_d, lo_d1_q, lo_d1_d;
    logic [LANES-1:0][17:0] xinfo_q, xinfo_d, yinfo_q, yinfo_d;

    logic [LANES-1:0]       x_uf, x_of, y_uf, y_of, x_hit, y_hit, pick;
    logic [LANES-1:0][15:0] data0_q, data0_d, data1_q, data1_d, frac_q, frac_d;
    logic [LANES-1:0]       sel_q, sel_d;
    logic [LANES-1:0][3:0]  flag_q, flag_d;

    // Out-of-range write addresses are dropped rather than wrapped.
    always_comb begin
        le_we = lut_wr_en && !lut_wr_table && (lut_wr_addr < LE_DEPTH_A);
        lo_we = lut_wr_en &&  lut_wr_table && (lut_wr_addr < LO_DEPTH_A);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < LE_DEPTH; i++) le_tab_q[i] <= '0;
            for (int i = 0; i < LO_DEPTH; i++) lo_tab_q[i] <= '0;
        end else begin
            if (le_we) le_tab_q[lut_wr_addr[LE_AW-1:0]] <= lut_wr_data;
            if (lo_we) lo_tab_q[lut_wr_addr[LO_AW-1:0]] <= lut_wr_data;
        end
    end

    always_comb begin
        s2_adv      = !s2_vld_q || lut2intp_prdy;
        s1_adv      = !s1_vld_q || s2_adv;
        dp2lut_prdy = s1_adv;
        s1_vld_d    = s1_adv ? dp2lut_pvld : s1_vld_q;
        s2_vld_d    = s2_adv ? s1_vld_q : s2_vld_q;
    end

    // S1: table reads use the pre-edge contents, so a same-cycle write is not seen.
    always_comb begin
        le_d0_d = le_d0_q;
        le_d1_d = le_d1_q;
        lo_d0_d = lo_d0_q;
        lo_d1_d = lo_d1_q;
        xinfo_d = xinfo_q;
        yinfo_d = yinfo_q;
        x_ent = '0; y_ent = '0; x_n = '0; x_n1 = '0; y_n = '0; y_n1 = '0;
        for (int l = 0; l < LANES; l++) begin
            x_ent[l] = dp2lut_X_entry[l*10 +: 10];
            y_ent[l] = dp2lut_Y_entry[l*10 +: 10];
            x_n[l]   = (x_ent[l] >= LE_LAST) ? LE_LAST : x_ent[l];
            x_n1[l]  = (x_ent[l] >= LE_LAST) ? LE_LAST : x_ent[l] + 10'd1;
            y_n[l]   = (y_ent[l] >= LO_LAST) ? LO_LAST : y_ent[l];
            y_n1[l]  = (y_ent[l] >= LO_LAST) ? LO_LAST : y_ent[l] + 10'd1;
            if (s1_adv) begin
                le_d0_d[l]     = le_tab_q[x_n[l][LE_AW-1:0]];
                le_d1_d[l]     = le_tab_q[x_n1[l][LE_AW-1:0]];
                lo_d0_d[l]     = lo_tab_q[y_n[l][LO_AW-1:0]];
                lo_d1_d[l]     = lo_tab_q[y_n1[l][LO_AW-1:0]];
                xinfo_d[l]     = dp2lut_Xinfo[l*18 +: 18];
                yinfo_d[l]     = dp2lut_Yinfo[l*18 +: 18];
                xinfo_d[l][17] = dp2lut_Xinfo[l*18 + 17] | (x_ent[l] > LE_LAST);
                yinfo_d[l][17] = dp2lut_Yinfo[l*18 + 17] | (y_ent[l] > LO_LAST);
            end
        end
    end

    // S2: per-lane table arbitration; mixed uflow/oflow falls back to LE.
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        frac_d  = frac_q;
        sel_d   = sel_q;
        flag_d  = flag_q;
        x_uf = '0; x_of = '0; y_uf = '0; y_of = '0; x_hit = '0; y_hit = '0; pick = '0;
        for (int l = 0; l < LANES; l++) begin
            x_uf[l]  = xinfo_q[l][16];
            x_of[l]  = xinfo_q[l][17];
            y_uf[l]  = yinfo_q[l][16];
            y_of[l]  = yinfo_q[l][17];
            x_hit[l] = !x_uf[l] && !x_of[l];
            y_hit[l] = !y_uf[l] && !y_of[l];
            if (x_hit[l] && !y_hit[l])      pick[l] = 1'b0;
            else if (!x_hit[l] && y_hit[l]) pick[l] = 1'b1;
            else if (x_hit[l] && y_hit[l])  pick[l] = reg2dp_lut_hybrid_priority;
            else if (x_uf[l] && y_uf[l])    pick[l] = reg2dp_lut_uflow_priority;
            else if (x_of[l] && y_of[l])    pick[l] = reg2dp_lut_oflow_priority;
            else                            pick[l] = 1'b0;
            if (s2_adv && s1_vld_q) begin
                data0_d[l] = pick[l] ? lo_d0_q[l] : le_d0_q[l];
                data1_d[l] = pick[l] ? lo_d1_q[l] : le_d1_q[l];
                frac_d[l]  = pick[l] ? yinfo_q[l][15:0] : xinfo_q[l][15:0];
                sel_d[l]   = pick[l];
                flag_d[l]  = {y_of[l], y_uf[l], x_of[l], x_uf[l]};
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            le_d0_q  <= '0;
            le_d1_q  <= '0;
            lo_d0_q  <= '0;
            lo_d1_q  <= '0;
            xinfo_q  <= '0;
            yinfo_q  <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
            frac_q   <= '0;
            sel_q    <= '0;
            flag_q   <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            le_d0_q  <= le_d0_d;
            le_d1_q  <= le_d1_d;
            lo_d0_q  <= lo_d0_d;
            lo_d1_q  <= lo_d1_d;
            xinfo_q  <= xinfo_d;
            yinfo_q  <= yinfo_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            frac_q   <= frac_d;
            sel_q    <= sel_d;
            flag_q   <= flag_d;
        end
    end

    assign lut2intp_pvld  = s2_vld_q;
    assign lut2intp_data0 = data0_q;
    assign lut2intp_data1 = data1_q;
    assign lut2intp_frac  = frac_q;
    assign lut2intp_sel   = sel_q;
    assign lut2intp_flag  = flag_q;

`ifdef NVDLA_CDP_LUT_RDBACK_EN
    logic [15:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (lut_rd_en) begin
            if (!lut_rd_table)
                rd_data_d = (lut_rd_addr < LE_DEPTH_A) ? le_tab_q[lut_rd_addr[LE_AW-1:0]] : 16'h0;
            else
                rd_data_d = (lut_rd_addr < LO_DEPTH_A) ? lo_tab_q[lut_rd_addr[LO_AW-1:0]] : 16'h0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) rd_data_q <= '0;
        else                  rd_data_q <= rd_data_d;
    end

    assign lut_rd_data = rd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nvdla_cdp_dp_lut_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_nvdla_cdp_dp_lut_rd
// Desc     : Directed self-checking bench for nvdla_cdp_dp_lut_rd.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nvdla_cdp_dp_lut_rd;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dp2lut_pvld, dp2lut_prdy;
    logic [9:0]  x_entry, y_entry;
    logic [17:0] xinfo, yinfo;
    logic        hyb_pri, uf_pri, of_pri;
    logic        wr_en, wr_table;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic        out_pvld, out_prdy;
    logic [15:0] out_d0, out_d1, out_frac;
    logic        out_sel;
    logic [3:0]  out_flag;
`ifdef NVDLA_CDP_LUT_RDBACK_EN
    logic        rd_en = 1'b0, rd_table = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic [15:0] rd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nvdla_cdp_dp_lut_rd dut (
        .nvdla_core_clk             (clk),
        .nvdla_core_rstn            (rstn),
        .dp2lut_pvld                (dp2lut_pvld),
        .dp2lut_prdy                (dp2lut_prdy),
        .dp2lut_X_entry             (x_entry),
        .dp2lut_Xinfo               (xinfo),
        .dp2lut_Y_entry             (y_entry),
        .dp2lut_Yinfo               (yinfo),
        .reg2dp_lut_hybrid_priority (hyb_pri),
        .reg2dp_lut_uflow_priority  (uf_pri),
        .reg2dp_lut_oflow_priority  (of_pri),
        .lut_wr_en                  (wr_en),
        .lut_wr_table               (wr_table),
        .lut_wr_addr                (wr_addr),
        .lut_wr_data                (wr_data),
`ifdef NVDLA_CDP_LUT_RDBACK_EN
        .lut_rd_en                  (rd_en),
        .lut_rd_table               (rd_table),
        .lut_rd_addr                (rd_addr),
        .lut_rd_data                (rd_data),
`endif
        .lut2intp_pvld              (out_pvld),
        .lut2intp_prdy              (out_prdy),
        .lut2intp_data0             (out_d0),
        .lut2intp_data1             (out_d1),
        .lut2intp_frac              (out_frac),
        .lut2intp_sel               (out_sel),
        .lut2intp_flag              (out_flag)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] inf(input bit of, input bit uf, input logic [15:0] fr);
        return {of, uf, fr};
    endfunction

    task automatic send(input logic [9:0] x, input logic [17:0] xi,
                        input logic [9:0] y, input logic [17:0] yi);
        dp2lut_pvld = 1'b1;
        x_entry = x; xinfo = xi; y_entry = y; yinfo = yi;
        tick();
        dp2lut_pvld = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] fr, input logic s, input logic [3:0] fl);
        int n = 0;
        while (!out_pvld && n < 8) begin
            tick();
            n++;
        end
        chk({tag, ".pvld"}, 32'(out_pvld), 32'd1);
        chk({tag, ".data0"}, 32'(out_d0), 32'(d0));
        chk({tag, ".data1"}, 32'(out_d1), 32'(d1));
        chk({tag, ".frac"}, 32'(out_frac), 32'(fr));
        chk({tag, ".sel"}, 32'(out_sel), 32'(s));
        chk({tag, ".flag"}, 32'(out_flag), 32'(fl));
        tick();
    endtask

    // Cycle-accurate occupancy model of the two stages drives the prdy/pvld expectations.
    task automatic stream(input bit toggle, input string tag);
        int sent = 0;
        int recv = 0;
        int k;
        bit m_s1 = 1'b0, m_s2 = 1'b0, s2a, ep, saw_low = 1'b0;
        int q[$];
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            dp2lut_pvld = (sent < 20);
            x_entry = 10'(sent);
            xinfo   = inf(1'b0, 1'b0, 16'(sent * 7));
            y_entry = 10'(sent + 30);
            yinfo   = inf(1'b0, 1'b0, 16'h0);
            out_prdy = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            s2a = !m_s2 || out_prdy;
            ep  = !m_s1 || s2a;
            if (!ep) saw_low = 1'b1;
            chk({tag, ".prdy"}, 32'(dp2lut_prdy), 32'(ep));
            chk({tag, ".pvld"}, 32'(out_pvld), 32'(m_s2));
            if (m_s2 && out_prdy) begin
                if (q.size() == 0) begin
                    chk({tag, ".extra"}, 32'(q.size()), 32'd1);
                end else begin
                    k = q.pop_front();
                    chk({tag, ".data0"}, 32'(out_d0), 32'(k * 3));
                    chk({tag, ".data1"}, 32'(out_d1), 32'(k * 3 + 3));
                    chk({tag, ".frac"}, 32'(out_frac), 32'(k * 7));
                end
                recv++;
            end
            if (dp2lut_pvld && ep) begin
                q.push_back(sent);
                sent++;
            end
            m_s2 = s2a ? m_s1 : m_s2;
            m_s1 = ep ? dp2lut_pvld : m_s1;
            @(posedge clk);
            #1;
        end
        dp2lut_pvld = 1'b0;
        out_prdy = 1'b1;
        chk({tag, ".recv"}, 32'(recv), 32'd20);
        chk({tag, ".sent"}, 32'(sent), 32'd20);
        chk({tag, ".stall_seen"}, 32'(saw_low), 32'(toggle));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        dp2lut_pvld = 1'b0; x_entry = '0; y_entry = '0; xinfo = '0; yinfo = '0;
        hyb_pri = 1'b0; uf_pri = 1'b0; of_pri = 1'b0;
        wr_en = 1'b0; wr_table = 1'b0; wr_addr = '0; wr_data = '0;
        out_prdy = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst.pvld", 32'(out_pvld), 32'd0);
        chk("rst.prdy", 32'(dp2lut_prdy), 32'd1);
        chk("rst.data0", 32'(out_d0), 32'd0);
        chk("rst.flag", 32'(out_flag), 32'd0);
        rstn = 1'b1;
        tick();

        // Table load: LE[i]=i*3, LO[i]=0x1000+i
        for (int i = 0; i < 65; i++) begin
            wr_en = 1'b1; wr_table = 1'b0; wr_addr = 9'(i); wr_data = 16'(i * 3);
            tick();
        end
        for (int i = 0; i < 257; i++) begin
            wr_en = 1'b1; wr_table = 1'b1; wr_addr = 9'(i); wr_data = 16'(16'h1000 + i);
            tick();
        end
        wr_en = 1'b0;

        // Both hit, latency of two edges from the accepting edge
        send(10'd5, inf(0, 0, 16'h1234), 10'd7, inf(0, 0, 16'h5678));
        chk("lat.s1", 32'(out_pvld), 32'd0);
        tick();
        chk("lat.s2", 32'(out_pvld), 32'd1);
        expect_out("hit_le", 16'd15, 16'd18, 16'h1234, 1'b0, 4'b0000);

        hyb_pri = 1'b1;
        send(10'd5, inf(0, 0, 16'h1234), 10'd7, inf(0, 0, 16'h5678));
        expect_out("hit_lo", 16'h1007, 16'h1008, 16'h5678, 1'b1, 4'b0000);
        send(10'd63, inf(0, 0, 16'h0001), 10'd256, inf(0, 0, 16'h0002));
        expect_out("lo_last", 16'h1100, 16'h1100, 16'h0002, 1'b1, 4'b0000);
        hyb_pri = 1'b0;
        send(10'd63, inf(0, 0, 16'h0001), 10'd256, inf(0, 0, 16'h0002));
        expect_out("le_63", 16'd189, 16'd192, 16'h0001, 1'b0, 4'b0000);

        // Clamp / forced oflow
        send(10'd64, inf(0, 0, 16'h0011), 10'd300, inf(0, 0, 16'h0022));
        expect_out("le_last", 16'd192, 16'd192, 16'h0011, 1'b0, 4'b1000);
        of_pri = 1'b1;
        send(10'd70, inf(0, 0, 16'h0011), 10'd300, inf(0, 0, 16'h0022));
        expect_out("both_of_lo", 16'h1100, 16'h1100, 16'h0022, 1'b1, 4'b1010);
        of_pri = 1'b0;
        send(10'd70, inf(0, 0, 16'h0011), 10'd300, inf(0, 0, 16'h0022));
        expect_out("both_of_le", 16'd192, 16'd192, 16'h0011, 1'b0, 4'b1010);

        // Underflow arbitration
        uf_pri = 1'b1;
        send(10'd3, inf(0, 1, 16'hAAAA), 10'd4, inf(0, 1, 16'hBBBB));
        expect_out("both_uf_lo", 16'h1004, 16'h1005, 16'hBBBB, 1'b1, 4'b0101);
        uf_pri = 1'b0;
        send(10'd3, inf(0, 1, 16'hAAAA), 10'd4, inf(0, 1, 16'hBBBB));
        expect_out("both_uf_le", 16'd9, 16'd12, 16'hAAAA, 1'b0, 4'b0101);

        // Mixed uflow/oflow falls to LE regardless of priorities
        hyb_pri = 1'b1; uf_pri = 1'b1; of_pri = 1'b1;
        send(10'd3, inf(0, 1, 16'hAAAA), 10'd4, inf(1, 0, 16'hBBBB));
        expect_out("mixed", 16'd9, 16'd12, 16'hAAAA, 1'b0, 4'b1001);
        hyb_pri = 1'b0; uf_pri = 1'b0; of_pri = 1'b0;
        send(10'd3, inf(0, 1, 16'hAAAA), 10'd4, inf(0, 0, 16'hBBBB));
        expect_out("only_lo", 16'h1004, 16'h1005, 16'hBBBB, 1'b1, 4'b0001);

        // Streaming
        stream(1'b1, "strm_tgl");
        stream(1'b0, "strm_full");

        // Write/read collision on LO[7]
        hyb_pri = 1'b1;
        dp2lut_pvld = 1'b1;
        x_entry = 10'd5; xinfo = inf(0, 0, 16'h0); y_entry = 10'd7; yinfo = inf(0, 0, 16'h0);
        wr_en = 1'b1; wr_table = 1'b1; wr_addr = 9'd7; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        tick();
        dp2lut_pvld = 1'b0;
        chk("coll.old_pvld", 32'(out_pvld), 32'd1);
        chk("coll.old_d0", 32'(out_d0), 32'h1007);
        chk("coll.old_d1", 32'(out_d1), 32'h1008);
        tick();
        chk("coll.new_pvld", 32'(out_pvld), 32'd1);
        chk("coll.new_d0", 32'(out_d0), 32'hBEEF);
        tick();
        chk("coll.drain", 32'(out_pvld), 32'd0);

        // Reset mid-stream with a stalled, full pipeline
        hyb_pri = 1'b0;
        out_prdy = 1'b0;
        dp2lut_pvld = 1'b1;
        x_entry = 10'd5; xinfo = inf(0, 0, 16'h0); y_entry = 10'd7; yinfo = inf(0, 0, 16'h0);
        repeat (3) tick();
        chk("stall.pvld", 32'(out_pvld), 32'd1);
        chk("stall.prdy", 32'(dp2lut_prdy), 32'd0);
        tick();
        chk("stall.d0_stable", 32'(out_d0), 32'd15);
        rstn = 1'b0;
        #1;
        chk("midrst.pvld", 32'(out_pvld), 32'd0);
        chk("midrst.d0", 32'(out_d0), 32'd0);
        dp2lut_pvld = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        out_prdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst.no_pulse", 32'(out_pvld), 32'd0);
        end
        send(10'd5, inf(0, 0, 16'h0042), 10'd7, inf(0, 0, 16'h0043));
        expect_out("postrst_le", 16'd0, 16'd0, 16'h0042, 1'b0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
